// File: rtl/data_memory_responder_if.sv
// rtl/data_memory_responder_if.sv - CPU data-memory request/response bundle
interface data_memory_responder_if;
    logic        data_memory_req;
    logic        data_memory_we;
    logic [31:0] data_memory_a;
    logic [31:0] data_memory_wd;
    logic [31:0] data_memory_rd;
    logic        data_memory_ready;
    logic        data_memory_err;
    logic        data_memory_busy;

    modport master (
        output data_memory_req,
        output data_memory_we,
        output data_memory_a,
        output data_memory_wd,
        input  data_memory_rd,
        input  data_memory_ready,
        input  data_memory_err,
        input  data_memory_busy
    );

    modport slave (
        input  data_memory_req,
        input  data_memory_we,
        input  data_memory_a,
        input  data_memory_wd,
        output data_memory_rd,
        output data_memory_ready,
        output data_memory_err,
        output data_memory_busy
    );
endinterface

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - latency-configurable word RAM responder for the CPU load/store port
module data_memory_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    data_memory_responder_if.slave  dmem
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_cnt;
    logic [4:0]      w_cnt_nxt;
    logic            w_accept;

    logic            r_we;
    logic [31:0]     r_a;
    logic [31:0]     r_wd;

    logic [31:0]     r_rd;
    logic            r_ready;
    logic            r_err;
    logic            r_busy;

    logic [31:0]     r_mem [DEPTH];

    logic            w_sel_we;
    logic [31:0]     w_sel_a;
    logic [AW-1:0]   w_sel_idx;
    logic            w_sel_bad;
    logic [31:0]     w_rd_nxt;
    logic [AW-1:0]   w_wr_idx;
    logic            w_wr_en;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= BYTE_LIMIT);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dmem.data_memory_req) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = 5'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 5'd1;
                if (r_cnt <= 5'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // With LATENCY=1 the response is formed on the accept edge, before the request is latched.
    always_comb begin
        w_sel_we  = w_accept ? dmem.data_memory_we : r_we;
        w_sel_a   = w_accept ? dmem.data_memory_a  : r_a;
        w_sel_idx = w_sel_a[AW+1:2];
        w_sel_bad = addr_bad(w_sel_a);
        w_rd_nxt  = 32'd0;
        if (!w_sel_bad && !w_sel_we) begin
            w_rd_nxt = r_mem[w_sel_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_we    <= 1'b0;
            r_a     <= 32'd0;
            r_wd    <= 32'd0;
            r_rd    <= 32'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == S_RESP);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_err   <= (w_state_nxt == S_RESP) && w_sel_bad;
            if (w_accept) begin
                r_we <= dmem.data_memory_we;
                r_a  <= dmem.data_memory_a;
                r_wd <= dmem.data_memory_wd;
            end
            if (w_state_nxt == S_RESP) begin
                r_rd <= w_rd_nxt;
            end
        end
    end

    // Store commits on the edge leaving RESP; a reset on that edge abandons it.
    assign w_wr_idx = r_a[AW+1:2];
    assign w_wr_en  = !rst && (r_state == S_RESP) && r_we && !addr_bad(r_a);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= r_wd;
        end
    end

    assign dmem.data_memory_rd    = r_rd;
    assign dmem.data_memory_ready = r_ready;
    assign dmem.data_memory_err   = r_err;
    assign dmem.data_memory_busy  = r_busy;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - scoreboard bench for data_memory_responder
module tb_data_memory_responder;

    localparam int MAIN_LAT = 2;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic clk;
    logic rst;
    logic sw_rst;
    int   cyc;
    int   n_vec;
    int   n_bad;
    int   sw_done_cnt;
    logic mon_en;
    logic [31:0] last_rd;
    exp_t sb_q[$];
    exp_t mon_e;

    data_memory_responder_if dmem();

    data_memory_responder #(.DEPTH(1024), .LATENCY(MAIN_LAT)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .dmem (dmem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) if (rst) last_rd = 32'd0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (dmem.data_memory_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_ready: got ready=1 at cycle %0d expected no response", cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("ready_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("resp_err", 32'(dmem.data_memory_err), 32'(mon_e.err));
                    chk("resp_rd", dmem.data_memory_rd, mon_e.rd);
                    last_rd = mon_e.rd;
                end
            end else begin
                chk("err_idle", 32'(dmem.data_memory_err), 32'd0);
                chk("rd_hold", dmem.data_memory_rd, last_rd);
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rd);
        exp_t e;
        @(posedge clk); #1;
        dmem.data_memory_req = 1'b1;
        dmem.data_memory_we  = we;
        dmem.data_memory_a   = a;
        dmem.data_memory_wd  = wd;
        e.cyc = cyc + MAIN_LAT;
        e.err = e_err;
        e.rd  = e_rd;
        sb_q.push_back(e);
        @(posedge clk); #1;
        dmem.data_memory_req = 1'b0;
        @(posedge clk);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 5 : 16);
        data_memory_responder_if sw_bus();
        int exp_q[$];
        int k;
        int c;
        int got;

        data_memory_responder #(.DEPTH(16), .LATENCY(LAT)) u_sw (
            .clk  (clk),
            .rst  (sw_rst),
            .dmem (sw_bus)
        );

        always @(negedge clk) begin
            if (!sw_rst && sw_bus.data_memory_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL sw_spurious_ready: got ready=1 at cycle %0d expected none (LAT=%0d)", cyc, LAT);
                end else begin
                    got = exp_q.pop_front();
                    chk("sw_ready_cycle", 32'(cyc), 32'(got));
                    chk("sw_err", 32'(sw_bus.data_memory_err), 32'd0);
                end
            end
        end

        initial begin
            sw_bus.data_memory_req = 1'b0;
            sw_bus.data_memory_we  = 1'b1;
            sw_bus.data_memory_a   = 32'd0;
            sw_bus.data_memory_wd  = 32'hA5A5_0000;
            wait (sw_rst == 1'b0);
            repeat (3) @(posedge clk);
            #1;
            sw_bus.data_memory_req = 1'b1;
            k = cyc;
            exp_q.push_back(k + LAT);
            exp_q.push_back(k + 2 * LAT + 1);
            for (int i = 0; i < 2 * LAT + 5; i++) begin
                @(negedge clk);
                c = cyc - k;
                chk("sw_busy", 32'(sw_bus.data_memory_busy),
                    32'(((c >= 1) && (c <= LAT)) || ((c >= LAT + 2) && (c <= 2 * LAT + 1))));
                if (c == 2 * LAT + 1) sw_bus.data_memory_req = 1'b0;
            end
            chk("sw_drain", 32'(exp_q.size()), 32'd0);
            sw_done_cnt++;
        end
    end

    initial begin
        exp_t e;
        int k;
        n_vec = 0;
        n_bad = 0;
        sw_done_cnt = 0;
        mon_en = 1'b0;
        last_rd = 32'd0;
        rst = 1'b1;
        sw_rst = 1'b1;
        dmem.data_memory_req = 1'b0;
        dmem.data_memory_we  = 1'b0;
        dmem.data_memory_a   = 32'd0;
        dmem.data_memory_wd  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sw_rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_ready", 32'(dmem.data_memory_ready), 32'd0);
            chk("rst_busy", 32'(dmem.data_memory_busy), 32'd0);
            chk("rst_rd", dmem.data_memory_rd, 32'd0);
        end

        issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
        issue(1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);
        issue(1'b1, 32'h12, 32'h11111111, 1'b1, 32'd0);
        issue(1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);
        issue(1'b0, 32'h1000, 32'd0, 1'b1, 32'd0);
        issue(1'b0, 32'h11, 32'd0, 1'b1, 32'd0);
        issue(1'b1, 32'hFFC, 32'h13579BDF, 1'b0, 32'd0);
        issue(1'b0, 32'hFFC, 32'd0, 1'b0, 32'h13579BDF);
        issue(1'b0, 32'hFFFF_FFFC, 32'd0, 1'b1, 32'd0);
        issue(1'b1, 32'h20, 32'h0BADF00D, 1'b0, 32'd0);

        // Store abandoned by a reset while in WAIT.
        @(posedge clk); #1;
        dmem.data_memory_req = 1'b1;
        dmem.data_memory_we  = 1'b1;
        dmem.data_memory_a   = 32'h20;
        dmem.data_memory_wd  = 32'h12345678;
        @(posedge clk); #1;
        dmem.data_memory_req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(dmem.data_memory_busy), 32'd0);
        chk("mid_rst_rd", dmem.data_memory_rd, 32'd0);
        issue(1'b0, 32'h20, 32'd0, 1'b0, 32'h0BADF00D);

        // Reset and request in the same cycle: request dropped.
        @(posedge clk); #1;
        rst = 1'b1;
        dmem.data_memory_req = 1'b1;
        dmem.data_memory_we  = 1'b1;
        dmem.data_memory_a   = 32'h10;
        dmem.data_memory_wd  = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b0;
        dmem.data_memory_req = 1'b0;
        @(negedge clk);
        chk("rst_req_busy", 32'(dmem.data_memory_busy), 32'd0);
        repeat (4) @(posedge clk);
        issue(1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);

        // Request held high for three back-to-back transactions.
        @(posedge clk); #1;
        dmem.data_memory_req = 1'b1;
        dmem.data_memory_we  = 1'b0;
        dmem.data_memory_a   = 32'h10;
        k = cyc;
        for (int i = 0; i < 3; i++) begin
            e.cyc = k + i * (MAIN_LAT + 1) + MAIN_LAT;
            e.err = 1'b0;
            e.rd  = 32'hDEADBEEF;
            sb_q.push_back(e);
        end
        repeat (3 * (MAIN_LAT + 1)) @(posedge clk);
        #1;
        dmem.data_memory_req = 1'b0;
        repeat (6) @(posedge clk);

        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        for (int i = 0; i < 500 && sw_done_cnt < 3; i++) @(posedge clk);
        chk("sweep_done", 32'(sw_done_cnt), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
